// File: rtl/hqm_list_sel_mem_aw_sram_ctl_2048x139_if.sv
// Request/response handshake between list_sel pipeline logic and the AW SRAM controller.
interface hqm_list_sel_mem_aw_sram_ctl_2048x139_if #(
   parameter int AW = 11,
   parameter int DW = 139
);
   logic          req_v;
   logic          req_rdy;
   logic          req_we;
   logic [AW-1:0] req_addr;
   logic [DW-1:0] req_wdata;
   logic          rsp_v;
   logic          rsp_rdy;
   logic [DW-1:0] rsp_rdata;

   modport master (
      output req_v, req_we, req_addr, req_wdata, rsp_rdy,
      input  req_rdy, rsp_v, rsp_rdata
   );

   modport slave (
      input  req_v, req_we, req_addr, req_wdata, rsp_rdy,
      output req_rdy, rsp_v, rsp_rdata
   );
endinterface

// File: rtl/hqm_list_sel_mem_aw_sram_ctl_2048x139.sv
// Requester-side controller for the 2048x139 power-gated list_sel AW SRAM: zero-init sweep,
// registered SRAM strobes, fixed-latency read capture and a credit-protected response FIFO.
module hqm_list_sel_mem_aw_sram_ctl_2048x139 #(
   parameter int DEPTH     = 2048,
   parameter int AW        = 11,
   parameter int DW        = 139,
   parameter int RSP_DEPTH = 4
) (
   input  logic                                            clk,
   input  logic                                            clk_rst_n,
   input  logic                                            mem_pwr_off,
   hqm_list_sel_mem_aw_sram_ctl_2048x139_if.slave          bus,
   output logic                                            init_done,
   output logic                                            mem_re,
   output logic                                            mem_we,
   output logic [AW-1:0]                                   mem_addr,
   output logic [DW-1:0]                                   mem_wdata,
   input  logic [DW-1:0]                                   mem_rdata
);
   localparam int CW = $clog2(RSP_DEPTH + 1);
   // FIFO pointers wrap naturally, so RSP_DEPTH must be a power of two.
   localparam int PW = $clog2(RSP_DEPTH);

   typedef enum logic [1:0] {ST_OFF, ST_INIT, ST_RUN} state_t;

   state_t        state;
   logic [AW:0]   init_cnt;
   logic [CW-1:0] cnt;
   logic [CW-1:0] fifo_cnt;
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic          rd_pend;
   logic [DW-1:0] fifo_mem [RSP_DEPTH];

   logic req_acc;
   logic rd_acc;
   logic rsp_v;
   logic pop;

   assign bus.req_rdy   = (state == ST_RUN) && !mem_pwr_off && (cnt < CW'(RSP_DEPTH));
   assign req_acc       = bus.req_v && bus.req_rdy;
   assign rd_acc        = req_acc && !bus.req_we;
   assign rsp_v         = (fifo_cnt != '0);
   assign pop           = rsp_v && bus.rsp_rdy;
   assign bus.rsp_v     = rsp_v;
   assign bus.rsp_rdata = rsp_v ? fifo_mem[rd_ptr] : '0;

   // NOTE: every register here is updated with <= so all blocks sample pre-edge values.
   always_ff @(posedge clk) begin
      if (!clk_rst_n) begin
         state     <= mem_pwr_off ? ST_OFF : ST_INIT;
         init_cnt  <= '0;
         init_done <= 1'b0;
         mem_re    <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
      end else begin
         mem_re <= 1'b0;
         mem_we <= 1'b0;
         unique case (state)
            ST_OFF: begin
               if (!mem_pwr_off) begin
                  state    <= ST_INIT;
                  init_cnt <= '0;
               end
            end
            ST_INIT: begin
               if (mem_pwr_off) begin
                  state <= ST_OFF;
               end else if (init_cnt == (AW+1)'(DEPTH)) begin
                  state     <= ST_RUN;
                  init_done <= 1'b1;
               end else begin
                  mem_we    <= 1'b1;
                  mem_addr  <= init_cnt[AW-1:0];
                  mem_wdata <= '0;
                  init_cnt  <= init_cnt + (AW+1)'(1);
               end
            end
            ST_RUN: begin
               // Reads already issued keep flowing through the capture/FIFO path below.
               if (mem_pwr_off) begin
                  state     <= ST_OFF;
                  init_done <= 1'b0;
               end
               if (req_acc) begin
                  mem_re   <= !bus.req_we;
                  mem_we   <= bus.req_we;
                  mem_addr <= bus.req_addr;
                  if (bus.req_we) mem_wdata <= bus.req_wdata;
               end
            end
            default: state <= ST_OFF;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!clk_rst_n) begin
         cnt      <= '0;
         fifo_cnt <= '0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         rd_pend  <= 1'b0;
      end else begin
         rd_pend <= mem_re;
         if (rd_acc && !pop)      cnt <= cnt + CW'(1);
         else if (!rd_acc && pop) cnt <= cnt - CW'(1);
         if (rd_pend && !pop)      fifo_cnt <= fifo_cnt + CW'(1);
         else if (!rd_pend && pop) fifo_cnt <= fifo_cnt - CW'(1);
         if (rd_pend) wr_ptr <= wr_ptr + PW'(1);
         if (pop)     rd_ptr <= rd_ptr + PW'(1);
      end
   end

   // NOTE: FIFO storage is deliberately not reset; rsp_rdata is masked to 0 while empty.
   always_ff @(posedge clk) begin
      if (rd_pend) fifo_mem[wr_ptr] <= mem_rdata;
   end
endmodule

// File: tb/tb_hqm_list_sel_mem_aw_sram_ctl_2048x139.sv
// Directed bench for the list_sel AW SRAM controller with a behavioural 1-cycle-latency SRAM.
module tb_hqm_list_sel_mem_aw_sram_ctl_2048x139;
   logic         clk = 1'b0;
   logic         clk_rst_n;
   logic         mem_pwr_off;
   logic         init_done;
   logic         mem_re;
   logic         mem_we;
   logic [10:0]  mem_addr;
   logic [138:0] mem_wdata;
   logic [138:0] mem_rdata;
   logic [138:0] sram [2048];

   int n_checks = 0;
   int n_errors = 0;

   hqm_list_sel_mem_aw_sram_ctl_2048x139_if #(.AW(11), .DW(139)) bus ();

   hqm_list_sel_mem_aw_sram_ctl_2048x139 dut (
      .clk         (clk),
      .clk_rst_n   (clk_rst_n),
      .mem_pwr_off (mem_pwr_off),
      .bus         (bus),
      .init_done   (init_done),
      .mem_re      (mem_re),
      .mem_we      (mem_we),
      .mem_addr    (mem_addr),
      .mem_wdata   (mem_wdata),
      .mem_rdata   (mem_rdata)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (mem_we) sram[mem_addr] <= mem_wdata;
      if (mem_re) mem_rdata <= sram[mem_addr];
   end

   function automatic logic [138:0] pat(input int i);
      return {11'(i + 16), {4{32'hA500_0000 + 32'(i)}}};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_req();
      bus.req_v     = 1'b0;
      bus.req_we    = 1'b0;
      bus.req_addr  = '0;
      bus.req_wdata = '0;
   endtask

   task automatic drive_req(input logic we, input logic [10:0] a, input logic [138:0] d);
      bus.req_v     = 1'b1;
      bus.req_we    = we;
      bus.req_addr  = a;
      bus.req_wdata = d;
   endtask

   // Holds reset for the given number of edges and checks every output's reset value.
   task automatic apply_reset(input string tag, input int cycles);
      clk_rst_n = 1'b0;
      repeat (cycles) tick();
      n_checks++;
      if ({bus.req_rdy, bus.rsp_v, init_done, mem_re, mem_we} !== 5'b0) begin
         n_errors++;
         $display("FAIL %s ctl: got rdy/rsp_v/done/re/we=%b required 00000", tag,
                  {bus.req_rdy, bus.rsp_v, init_done, mem_re, mem_we});
      end
      n_checks++;
      if (bus.rsp_rdata !== '0) begin
         n_errors++;
         $display("FAIL %s rsp_rdata: got %h required 0", tag, bus.rsp_rdata);
      end
      n_checks++;
      if (mem_addr !== '0 || mem_wdata !== '0) begin
         n_errors++;
         $display("FAIL %s mem_bus: got addr=%h wdata=%h required 0 0", tag, mem_addr, mem_wdata);
      end
   endtask

   // Caller sits one cycle before the strobe for address 0 is expected.
   task automatic run_sweep(input string tag);
      int          bad;
      int          bad_k;
      logic        bad_we;
      logic [10:0] bad_addr;
      bad = 0;
      bad_k = -1;
      bad_we = 1'b0;
      bad_addr = '0;
      for (int k = 0; k < 2048; k++) begin
         tick();
         if (mem_we !== 1'b1 || mem_re !== 1'b0 || mem_addr !== 11'(k) || mem_wdata !== '0 ||
             init_done !== 1'b0 || bus.req_rdy !== 1'b0) begin
            if (bad == 0) begin
               bad_k = k;
               bad_we = mem_we;
               bad_addr = mem_addr;
            end
            bad++;
         end
      end
      n_checks++;
      if (bad != 0) begin
         n_errors++;
         $display("FAIL %s sweep: %0d bad cycles, first at step %0d got we=%b addr=%0d, required we=1 addr=%0d wdata=0 done=0 rdy=0",
                  tag, bad, bad_k, bad_we, bad_addr, bad_k);
      end
      tick();
      n_checks++;
      if (init_done !== 1'b1 || bus.req_rdy !== 1'b1 || mem_we !== 1'b0) begin
         n_errors++;
         $display("FAIL %s done: got init_done=%b req_rdy=%b mem_we=%b required 1 1 0",
                  tag, init_done, bus.req_rdy, mem_we);
      end
   endtask

   task automatic read_expect(input string tag, input logic [10:0] a, input logic [138:0] exp);
      tick();
      drive_req(1'b0, a, '0);
      #1;
      n_checks++;
      if (bus.req_rdy !== 1'b1) begin
         n_errors++;
         $display("FAIL %s rdy: got %b required 1", tag, bus.req_rdy);
      end
      tick();
      idle_req();
      n_checks++;
      if (mem_re !== 1'b1 || mem_we !== 1'b0 || mem_addr !== a) begin
         n_errors++;
         $display("FAIL %s strobe: got re=%b we=%b addr=%h required 1 0 %h", tag, mem_re, mem_we, mem_addr, a);
      end
      tick();
      n_checks++;
      if (bus.rsp_v !== 1'b0) begin
         n_errors++;
         $display("FAIL %s early_rsp: got rsp_v=%b required 0", tag, bus.rsp_v);
      end
      tick();
      n_checks++;
      if (bus.rsp_v !== 1'b1 || bus.rsp_rdata !== exp) begin
         n_errors++;
         $display("FAIL %s rsp: got v=%b data=%h required 1 %h", tag, bus.rsp_v, bus.rsp_rdata, exp);
      end
   endtask

   task automatic test_reset();
      mem_pwr_off = 1'b0;
      bus.rsp_rdy = 1'b1;
      idle_req();
      apply_reset("reset", 3);
   endtask

   task automatic test_init_sweep();
      clk_rst_n = 1'b1;
      run_sweep("init");
      read_expect("init_rd_5a5", 11'h5A5, '0);
   endtask

   task automatic test_write_read();
      tick();
      drive_req(1'b1, 11'h7FF, '1);
      #1;
      n_checks++;
      if (bus.req_rdy !== 1'b1) begin
         n_errors++;
         $display("FAIL wr_rdy: got %b required 1", bus.req_rdy);
      end
      tick();
      idle_req();
      n_checks++;
      if (mem_we !== 1'b1 || mem_re !== 1'b0 || mem_addr !== 11'h7FF || mem_wdata !== {139{1'b1}}) begin
         n_errors++;
         $display("FAIL wr_strobe: got we=%b re=%b addr=%h wdata=%h required 1 0 7ff all-ones",
                  mem_we, mem_re, mem_addr, mem_wdata);
      end
      drive_req(1'b0, 11'h7FF, '0);
      #1;
      n_checks++;
      if (bus.req_rdy !== 1'b1) begin
         n_errors++;
         $display("FAIL rd_after_wr_rdy: got %b required 1", bus.req_rdy);
      end
      tick();
      idle_req();
      n_checks++;
      if (mem_re !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 11'h7FF) begin
         n_errors++;
         $display("FAIL rd_after_wr_strobe: got re=%b we=%b addr=%h required 1 0 7ff", mem_re, mem_we, mem_addr);
      end
      tick();
      n_checks++;
      if (bus.rsp_v !== 1'b0) begin
         n_errors++;
         $display("FAIL rd_after_wr_early: got rsp_v=%b required 0", bus.rsp_v);
      end
      tick();
      n_checks++;
      if (bus.rsp_v !== 1'b1 || bus.rsp_rdata !== {139{1'b1}}) begin
         n_errors++;
         $display("FAIL rd_after_wr_rsp: got v=%b data=%h required 1 all-ones", bus.rsp_v, bus.rsp_rdata);
      end
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 16; i++) begin
         tick();
         drive_req(1'b1, 11'(16 + i), pat(i));
         #1;
         n_checks++;
         if (bus.req_rdy !== 1'b1) begin
            n_errors++;
            $display("FAIL b2b_wr_rdy[%0d]: got %b required 1", i, bus.req_rdy);
         end
      end
      for (int c = 0; c < 20; c++) begin
         logic exp_v;
         tick();
         if (c < 16) drive_req(1'b0, 11'(16 + c), '0);
         else idle_req();
         #1;
         if (c < 16) begin
            n_checks++;
            if (bus.req_rdy !== 1'b1) begin
               n_errors++;
               $display("FAIL b2b_rd_rdy[%0d]: got %b required 1", c, bus.req_rdy);
            end
         end
         exp_v = (c >= 3) && (c < 19);
         n_checks++;
         if (bus.rsp_v !== exp_v) begin
            n_errors++;
            $display("FAIL b2b_rsp_v[%0d]: got %b required %b", c, bus.rsp_v, exp_v);
         end else if (exp_v) begin
            n_checks++;
            if (bus.rsp_rdata !== pat(c - 3)) begin
               n_errors++;
               $display("FAIL b2b_rsp_data[%0d]: got %h required %h", c, bus.rsp_rdata, pat(c - 3));
            end
         end
      end
   endtask

   task automatic test_backpressure();
      int acc;
      int got;
      acc = 0;
      got = 0;
      for (int c = 0; c < 10; c++) begin
         tick();
         bus.rsp_rdy = 1'b0;
         drive_req(1'b0, 11'(16 + acc), '0);
         #1;
         if (bus.req_rdy === 1'b1) acc++;
         if (bus.rsp_v === 1'b1) begin
            n_checks++;
            if (bus.rsp_rdata !== pat(0)) begin
               n_errors++;
               $display("FAIL bp_hold[%0d]: got %h required %h", c, bus.rsp_rdata, pat(0));
            end
         end
      end
      n_checks++;
      if (acc != 4 || bus.req_rdy !== 1'b0 || bus.rsp_v !== 1'b1) begin
         n_errors++;
         $display("FAIL bp_credit: got accepted=%0d req_rdy=%b rsp_v=%b required 4 0 1", acc, bus.req_rdy, bus.rsp_v);
      end
      for (int c = 0; c < 40 && got < 6; c++) begin
         tick();
         bus.rsp_rdy = 1'b1;
         if (acc < 6) drive_req(1'b0, 11'(16 + acc), '0);
         else idle_req();
         #1;
         if (bus.req_v && bus.req_rdy === 1'b1) acc++;
         if (bus.rsp_v === 1'b1) begin
            n_checks++;
            if (bus.rsp_rdata !== pat(got)) begin
               n_errors++;
               $display("FAIL bp_rsp[%0d]: got %h required %h", got, bus.rsp_rdata, pat(got));
            end
            got++;
         end
      end
      idle_req();
      n_checks++;
      if (acc != 6 || got != 6) begin
         n_errors++;
         $display("FAIL bp_drain: got accepted=%0d responses=%0d required 6 6", acc, got);
      end
   endtask

   task automatic test_power_off();
      int bad;
      bad = 0;
      tick();
      drive_req(1'b0, 11'd16, '0);
      #1;
      tick();
      drive_req(1'b0, 11'd17, '0);
      #1;
      n_checks++;
      if (bus.req_rdy !== 1'b1) begin
         n_errors++;
         $display("FAIL pwr_pre_rdy: got %b required 1", bus.req_rdy);
      end
      tick();
      mem_pwr_off = 1'b1;
      drive_req(1'b1, 11'd0, '1);
      #1;
      n_checks++;
      if (bus.req_rdy !== 1'b0 || mem_re !== 1'b1) begin
         n_errors++;
         $display("FAIL pwr_drop_rdy: got req_rdy=%b mem_re=%b required 0 1", bus.req_rdy, mem_re);
      end
      tick();
      idle_req();
      n_checks++;
      if (mem_we !== 1'b0 || init_done !== 1'b0 || bus.rsp_v !== 1'b1 || bus.rsp_rdata !== pat(0)) begin
         n_errors++;
         $display("FAIL pwr_rsp0: got we=%b done=%b v=%b data=%h required 0 0 1 %h",
                  mem_we, init_done, bus.rsp_v, bus.rsp_rdata, pat(0));
      end
      tick();
      n_checks++;
      if (bus.rsp_v !== 1'b1 || bus.rsp_rdata !== pat(1)) begin
         n_errors++;
         $display("FAIL pwr_rsp1: got v=%b data=%h required 1 %h", bus.rsp_v, bus.rsp_rdata, pat(1));
      end
      for (int c = 5; c < 12; c++) begin
         tick();
         if (mem_we !== 1'b0 || mem_re !== 1'b0 || bus.rsp_v !== 1'b0 || init_done !== 1'b0 || bus.req_rdy !== 1'b0)
            bad++;
      end
      n_checks++;
      if (bad != 0) begin
         n_errors++;
         $display("FAIL pwr_off_quiet: got %0d active cycles required 0", bad);
      end
      tick();
      mem_pwr_off = 1'b0;
      tick();
      n_checks++;
      if (mem_we !== 1'b0 || init_done !== 1'b0 || bus.req_rdy !== 1'b0) begin
         n_errors++;
         $display("FAIL pwr_on_gap: got we=%b done=%b rdy=%b required 0 0 0", mem_we, init_done, bus.req_rdy);
      end
      run_sweep("reinit");
      read_expect("reinit_rd", 11'd16, '0);
   endtask

   task automatic test_reset_mid_init();
      tick();
      bus.rsp_rdy = 1'b0;
      drive_req(1'b0, 11'd5, '0);
      tick();
      idle_req();
      tick();
      tick();
      n_checks++;
      if (bus.rsp_v !== 1'b1 || bus.rsp_rdata !== '0) begin
         n_errors++;
         $display("FAIL rst_pre_rsp: got v=%b data=%h required 1 0", bus.rsp_v, bus.rsp_rdata);
      end
      apply_reset("rst_fifo", 1);
      clk_rst_n = 1'b1;
      bus.rsp_rdy = 1'b1;
      for (int k = 1; k <= 1001; k++) tick();
      n_checks++;
      if (mem_we !== 1'b1 || mem_addr !== 11'd1000) begin
         n_errors++;
         $display("FAIL rst_mid_pos: got we=%b addr=%0d required 1 1000", mem_we, mem_addr);
      end
      apply_reset("rst_mid_init", 1);
      clk_rst_n = 1'b1;
      run_sweep("post_reset");
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      clk_rst_n   = 1'b0;
      mem_pwr_off = 1'b0;
      bus.rsp_rdy = 1'b1;
      idle_req();
      test_reset();
      test_init_sweep();
      test_write_read();
      test_back_to_back();
      test_backpressure();
      test_power_off();
      test_reset_mid_init();
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
